// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
package elevator_pkg;

    // Upper bound on served floors; floor masks are widened to this for the helpers.
    localparam int unsigned MAX_FLOORS  = 16;
    localparam int unsigned FLOOR_IDX_W = 4;

    // Car states kept as plain constants for compatibility with older consumers.
    typedef logic [1:0] state_t;
    localparam state_t IDLE      = 2'd0;
    localparam state_t MOVE_UP   = 2'd1;
    localparam state_t MOVE_DOWN = 2'd2;
    localparam state_t DOOR_OPEN = 2'd3;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    // Pending requests strictly above floor f.
    function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [MAX_FLOORS-1:0]  mask,
                                                         input logic [FLOOR_IDX_W-1:0] f);
        logic [MAX_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_FLOORS); i++) begin
            if (i > int'(f)) r[i] = mask[i];
        end
        return r;
    endfunction

    // Pending requests strictly below floor f.
    function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [MAX_FLOORS-1:0]  mask,
                                                         input logic [FLOOR_IDX_W-1:0] f);
        logic [MAX_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_FLOORS); i++) begin
            if (i < int'(f)) r[i] = mask[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter that parks at zero; used for travel and door timing.
module elevator_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    // Count down toward zero; a load takes priority over decrementing.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-style elevator car controller: latches floor calls, moves the car and times the door.
// Optional feature: define ELEVATOR_DOOR_HOLD_EN to add the door_hold input.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 4,
    parameter int unsigned FLOOR_W       = 2,
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned TRAVEL_W = $clog2(TRAVEL_CYCLES);
    localparam int unsigned DOOR_W   = $clog2(DOOR_CYCLES);

    state_t                state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  arrive_q, arrive_d;

    logic                  travel_load, travel_done;
    logic                  door_load, door_done;
    logic [TRAVEL_W-1:0]   travel_cnt;
    logic [DOOR_W-1:0]     door_cnt;
    logic                  hold;
    logic                  clr_en;
    logic [NUM_FLOORS-1:0] req_mask, clr_mask;
    logic [MAX_FLOORS-1:0] pend16;
    logic                  any_up, any_dn, any_fwd;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    assign pend16 = MAX_FLOORS'(pending_q);
    assign any_up = |above_mask(pend16, FLOOR_IDX_W'(floor_q));
    assign any_dn = |below_mask(pend16, FLOOR_IDX_W'(floor_q));

    elevator_timer #(
        .WIDTH    (TRAVEL_W)
    ) u_travel_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (travel_load),
        .load_val (TRAVEL_W'(TRAVEL_CYCLES - 1)),
        .count    (travel_cnt),
        .done     (travel_done)
    );

    elevator_timer #(
        .WIDTH    (DOOR_W)
    ) u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (door_load),
        .load_val (DOOR_W'(DOOR_CYCLES - 1)),
        .count    (door_cnt),
        .done     (door_done)
    );

    // Next-state decision for the car FSM, floor position and arrival pulse.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        floor_d     = floor_q;
        arrive_d    = 1'b0;
        clr_en      = 1'b0;
        travel_load = 1'b0;
        door_load   = 1'b0;
        any_fwd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend16[FLOOR_IDX_W'(floor_q)]) begin
                    state_d   = DOOR_OPEN;
                    clr_en    = 1'b1;
                    door_load = 1'b1;
                end else if (dir_q == DIR_UP ? any_up : any_dn) begin
                    state_d     = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                    travel_load = 1'b1;
                end else if (dir_q == DIR_UP ? any_dn : any_up) begin
                    dir_d       = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                    state_d     = (dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                    travel_load = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (travel_done) begin
                    floor_d  = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1)
                                                    : floor_q - FLOOR_W'(1);
                    arrive_d = 1'b1;
                    any_fwd  = (state_q == MOVE_UP)
                             ? |above_mask(pend16, FLOOR_IDX_W'(floor_d))
                             : |below_mask(pend16, FLOOR_IDX_W'(floor_d));
                    if (pend16[FLOOR_IDX_W'(floor_d)]) begin
                        state_d   = DOOR_OPEN;
                        clr_en    = 1'b1;
                        door_load = 1'b1;
                    end else if (any_fwd) begin
                        travel_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for this floor, or a hold, keeps the door open instead of latching.
                if ((req_valid && req_floor == floor_q) || hold) begin
                    door_load = 1'b1;
                end else if (door_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending mask update: servicing a floor wins over a same-edge call for it.
    always_comb begin
        req_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            req_mask[i] = req_valid && (req_floor == FLOOR_W'(i))
                        && !(state_q == DOOR_OPEN && floor_q == FLOOR_W'(i));
            clr_mask[i] = clr_en && (floor_d == FLOOR_W'(i));
        end
        pending_d = (pending_q | req_mask) & ~clr_mask;
    end

    // Car state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            pending_q <= '0;
            arrive_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            arrive_q  <= arrive_d;
        end
    end

    assign cur_floor   = floor_q;
    assign pending     = pending_q;
    assign arrive      = arrive_q;
    assign moving_up   = (state_q == MOVE_UP);
    assign moving_down = (state_q == MOVE_DOWN);
    assign door_open   = (state_q == DOOR_OPEN);

`ifndef SYNTHESIS
    floor_in_range: assert property (@(posedge clk) disable iff (rst)
        32'(floor_q) < NUM_FLOORS);
    travel_in_range: assert property (@(posedge clk) disable iff (rst)
        32'(travel_cnt) < TRAVEL_CYCLES);
    door_in_range: assert property (@(posedge clk) disable iff (rst)
        32'(door_cnt) < DOOR_CYCLES);
`endif

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler (default build and door-hold build).
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst, req_valid;
    logic [1:0] req_floor;
    logic [1:0] cur_floor;
    logic       moving_up, moving_down, door_open, arrive;
    logic [3:0] pending;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold;
`endif

    // Three-floor instance for out-of-range requests and mid-move reset.
    logic       rst3, req_valid3;
    logic [1:0] req_floor3;
    logic [1:0] cur_floor3;
    logic       moving_up3, moving_down3, door_open3, arrive3;
    logic [2:0] pending3;

    int errors = 0;
    int checks = 0;
    int n;
    logic act;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .NUM_FLOORS    (4),
        .FLOOR_W       (2),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold   (door_hold),
`endif
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .arrive      (arrive),
        .pending     (pending)
    );

    elevator_scheduler #(
        .NUM_FLOORS    (3),
        .FLOOR_W       (2),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (16)
    ) u_dut3 (
        .clk         (clk),
        .rst         (rst3),
        .req_valid   (req_valid3),
        .req_floor   (req_floor3),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold   (1'b0),
`endif
        .cur_floor   (cur_floor3),
        .moving_up   (moving_up3),
        .moving_down (moving_down3),
        .door_open   (door_open3),
        .arrive      (arrive3),
        .pending     (pending3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [1:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_door_open();
        int k = 0;
        while (!door_open && k < 100) begin
            tick();
            k++;
        end
        chk("door_open_timeout", door_open, 1);
    endtask

    // Returns the number of samples for which the door stayed open.
    task automatic count_door(output int cnt);
        cnt = 0;
        while (door_open && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_floor = '0;
        rst3 = 1'b1; req_valid3 = 1'b0; req_floor3 = '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        tick(); tick();
        chk("rst_cur_floor", cur_floor, 0);
        chk("rst_pending", pending, 0);
        chk("rst_arrive", arrive, 0);
        chk("rst_moving_up", moving_up, 0);
        chk("rst_moving_down", moving_down, 0);
        chk("rst_door_open", door_open, 0);
        rst = 1'b0; rst3 = 1'b0;

        // 1: idle with no requests stays quiet.
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            act = act | moving_up | moving_down | door_open | arrive | (|pending);
        end
        chk("idle_quiet", act, 0);

        // 2: floor 0 -> floor 2.
        request(2'd2);
        chk("t2_pending", pending, 4'b0100);
        chk("t2_not_moving_yet", moving_up, 0);
        tick();
        chk("t2_moving_up", moving_up, 1);
        n = 0;
        while (!arrive && n < 64) begin tick(); n++; end
        chk("t2_first_travel", n, 8);
        chk("t2_floor1", cur_floor, 1);
        tick();
        chk("t2_arrive_pulse", arrive, 0);
        n = 0;
        while (!arrive && n < 64) begin tick(); n++; end
        chk("t2_arrive_gap", n, 7);
        chk("t2_floor2", cur_floor, 2);
        chk("t2_door_open", door_open, 1);
        chk("t2_pending_clr", pending, 0);
        chk("t2_stopped", moving_up, 0);
        count_door(n);
        chk("t2_door_cycles", n, 16);

        // 3: at floor 1 heading up, calls for 0 and 3 -> serve 3 then 0.
        rst = 1'b1; tick(); rst = 1'b0;
        request(2'd1);
        wait_door_open();
        chk("t3_at_floor1", cur_floor, 1);
        request(2'd0);
        request(2'd3);
        chk("t3_pending", pending, 4'b1001);
        count_door(n);
        tick();
        chk("t3_up_first", moving_up, 1);
        wait_door_open();
        chk("t3_at_floor3", cur_floor, 3);
        chk("t3_pending_left", pending, 4'b0001);
        count_door(n);
        tick();
        chk("t3_reverse", moving_down, 1);
        wait_door_open();
        chk("t3_at_floor0", cur_floor, 0);
        chk("t3_pending_done", pending, 0);

        // 4: call for the current floor while the door is open restarts the door timer.
        count_door(n);
        request(2'd1);
        wait_door_open();
        chk("t4_at_floor1", cur_floor, 1);
        for (int i = 0; i < 5; i++) tick();
        request(2'd1);
        chk("t4_pending_unchanged", pending, 0);
        chk("t4_door_still_open", door_open, 1);
        count_door(n);
        chk("t4_door_restart", n, 16);

        // 5: out-of-range call ignored; reset mid-move drops everything.
        req_valid3 = 1'b1; req_floor3 = 2'd3; tick(); req_valid3 = 1'b0;
        chk("t5_oor_ignored", pending3, 0);
        tick(); tick(); tick();
        chk("t5_oor_no_move", moving_up3, 0);
        req_valid3 = 1'b1; req_floor3 = 2'd2; tick(); req_valid3 = 1'b0;
        chk("t5_pending", pending3, 3'b100);
        n = 0;
        while (!arrive3 && n < 64) begin tick(); n++; end
        chk("t5_floor1", cur_floor3, 1);
        tick(); tick(); tick();
        rst3 = 1'b1; req_valid3 = 1'b1; req_floor3 = 2'd1;
        tick();
        rst3 = 1'b0; req_valid3 = 1'b0;
        chk("t5_rst_floor", cur_floor3, 0);
        chk("t5_rst_pending", pending3, 0);
        chk("t5_rst_moving", moving_up3, 0);
        chk("t5_rst_arrive", arrive3, 0);
        chk("t5_rst_door", door_open3, 0);

`ifdef ELEVATOR_DOOR_HOLD_EN
        // 6: door_hold keeps the door open with no movement.
        request(2'd2);
        wait_door_open();
        door_hold = 1'b1;
        act = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            act = act | moving_up | moving_down | ~door_open;
        end
        door_hold = 1'b0;
        while (door_open && n < 200) begin tick(); n++; end
        chk("t6_held_open", act, 0);
        chk("t6_door_cycles", n, 56);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
